// File: rtl/rns_sub_sequencer.sv
// RNS subtraction sequencer: walks the residue channels one per cycle
// through a single shared combinational modular subtractor.
module rns_sub_sequencer #(
    parameter int RW       = 3,
    parameter int NCH      = 3,
    parameter int MOD0_RST = 7,
    parameter int MOD1_RST = 5,
    parameter int MOD2_RST = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*RW-1:0] a_res,
    input  logic [NCH*RW-1:0] b_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*RW-1:0] diff_res,
    output logic              out_err,
    output logic [RW-1:0]     sub_res1,
    output logic [RW-1:0]     sub_res2,
    output logic [RW-1:0]     sub_moduli,
    input  logic [RW-1:0]     sub_diff,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [RW-1:0]     cfg_mod,
    output logic              cfg_rej,
    output logic [7:0]        op_count
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]     ch_q;
    logic [NCH*RW-1:0] a_q;
    logic [NCH*RW-1:0] b_q;
    logic [NCH*RW-1:0] diff_q;
    logic [RW-1:0]     mod_q   [NCH];
    logic [RW-1:0]     mod_cap [NCH];
    logic              err_q;
    logic              rej_q;
    logic [7:0]        cnt_q;

    logic [RW-1:0] cur_a;
    logic [RW-1:0] cur_b;
    logic [RW-1:0] cur_m;
    logic          cur_bad;
    logic          cfg_ok;

    function automatic logic [RW-1:0] mod_rst(input int k);
        if (k == 0) return RW'(MOD0_RST);
        if (k == 1) return RW'(MOD1_RST);
        return RW'(MOD2_RST);
    endfunction

    // Select the current channel's operands and its snapshotted modulus
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        cur_m = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_q == CW'(k)) begin
                cur_a = a_q[k*RW +: RW];
                cur_b = b_q[k*RW +: RW];
                cur_m = mod_cap[k];
            end
        end
        cur_bad = (cur_a >= cur_m) || (cur_b >= cur_m) || (cur_m < RW'(2));
    end

    // Handshake and shared-subtractor outputs; subtractor idles at zero
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        diff_res   = diff_q;
        out_err    = err_q;
        cfg_rej    = rej_q;
        op_count   = cnt_q;
        sub_res1   = '0;
        sub_res2   = '0;
        sub_moduli = '0;
        if (state_q == CALC) begin
            sub_res1   = cur_a;
            sub_res2   = cur_b;
            sub_moduli = cur_m;
        end
        cfg_ok = (state_q == IDLE) && (int'(cfg_sel) < NCH);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (ch_q == CH_LAST) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-channel collection, moduli config and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            err_q  <= 1'b0;
            rej_q  <= 1'b0;
            cnt_q  <= '0;
            for (int k = 0; k < NCH; k++) begin
                mod_q[k]   <= mod_rst(k);
                mod_cap[k] <= mod_rst(k);
            end
        end else begin
            rej_q <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                for (int k = 0; k < NCH; k++) begin
                    if (int'(cfg_sel) == k) mod_q[k] <= cfg_mod;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_res;
                        b_q   <= b_res;
                        ch_q  <= '0;
                        err_q <= 1'b0;
                        // snapshot so a same-cycle cfg write is not seen
                        for (int k = 0; k < NCH; k++) begin
                            mod_cap[k] <= mod_q[k];
                        end
                    end
                end
                CALC: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (ch_q == CW'(k)) begin
                            diff_q[k*RW +: RW] <= cur_bad ? '0 : sub_diff;
                        end
                    end
                    if (cur_bad) err_q <= 1'b1;
                    ch_q <= ch_q + CW'(1);
                end
                DONE: begin
                    if (out_ready) cnt_q <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rns_sub_sequencer.sv
// Directed bench for rns_sub_sequencer with a behavioural shared
// modular subtractor attached to the sub_* ports.
module tb_rns_sub_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] a_res;
    logic [8:0] b_res;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] diff_res;
    logic       out_err;
    logic [2:0] sub_res1;
    logic [2:0] sub_res2;
    logic [2:0] sub_moduli;
    logic [2:0] sub_diff;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [2:0] cfg_mod;
    logic       cfg_rej;
    logic [7:0] op_count;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rns_sub_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_res      (a_res),
        .b_res      (b_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff_res   (diff_res),
        .out_err    (out_err),
        .sub_res1   (sub_res1),
        .sub_res2   (sub_res2),
        .sub_moduli (sub_moduli),
        .sub_diff   (sub_diff),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_mod    (cfg_mod),
        .cfg_rej    (cfg_rej),
        .op_count   (op_count)
    );

    // Shared subtractor: (res1 - res2) mod m, same cycle
    always_comb begin
        int d;
        int m;
        m = int'(sub_moduli);
        d = int'(sub_res1) - int'(sub_res2);
        sub_diff = '0;
        if (m != 0) sub_diff = 3'(((d % m) + m) % m);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] pk(input int c2, input int c1, input int c0);
        logic [2:0] x2;
        logic [2:0] x1;
        logic [2:0] x0;
        x2 = 3'(c2);
        x1 = 3'(c1);
        x0 = 3'(c0);
        return {x2, x1, x0};
    endfunction

    // Present operands after an edge; accept happens on the next edge,
    // then three CALC edges bring the block into DONE.
    task automatic run_op(input logic [8:0] a, input logic [8:0] b);
        a_res = a;
        b_res = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_res = '0;
        b_res = '0;
        cfg_we = 1'b0;
        cfg_sel = '0;
        cfg_mod = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_diff", 32'(diff_res), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_cfg_rej", 32'(cfg_rej), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_sub", 32'({sub_res1, sub_res2, sub_moduli}), 0);
        rst_n = 1'b1;

        // op1: a=(5,3,2) b=(2,4,1) with latency checks
        a_res = pk(2, 3, 5);
        b_res = pk(1, 4, 2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("op1_calc_in_ready", 32'(in_ready), 0);
        chk("op1_sub_ch0", 32'({sub_res1, sub_res2, sub_moduli}),
            32'({3'd5, 3'd2, 3'd7}));
        tick();
        tick();
        chk("op1_valid_early", 32'(out_valid), 0);
        tick();
        chk("op1_valid", 32'(out_valid), 1);
        chk("op1_diff", 32'(diff_res), 32'(pk(1, 4, 3)));
        chk("op1_err", 32'(out_err), 0);
        chk("op1_sub_idle", 32'({sub_res1, sub_res2, sub_moduli}), 0);
        handoff();
        chk("op1_count", 32'(op_count), 1);
        chk("op1_back_idle", 32'(in_ready), 1);

        // op2: wraparound on ch0, then stall 10 cycles in DONE
        run_op(pk(0, 0, 1), pk(0, 0, 6));
        chk("op2_diff", 32'(diff_res), 32'(pk(0, 0, 2)));
        chk("op2_err", 32'(out_err), 0);
        a_res = pk(1, 1, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_diff", 32'(diff_res), 32'(pk(0, 0, 2)));
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("op2_no_accept_at_handoff", 32'(in_ready), 1);
        chk("op2_count", 32'(op_count), 2);

        // op3: ch1 residue out of range
        run_op(pk(2, 6, 4), pk(0, 2, 1));
        chk("op3_diff", 32'(diff_res), 32'(pk(2, 0, 3)));
        chk("op3_err", 32'(out_err), 1);
        handoff();

        // op4: cfg write during CALC is rejected
        a_res = pk(0, 1, 0);
        b_res = pk(0, 3, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_sel = 2'd1;
        cfg_mod = 3'd4;
        tick();
        cfg_we = 1'b0;
        chk("calc_cfg_rej", 32'(cfg_rej), 1);
        chk("calc_mod_ch1", 32'(sub_moduli), 5);
        tick();
        chk("calc_cfg_rej_pulse", 32'(cfg_rej), 0);
        tick();
        chk("op4_diff", 32'(diff_res), 32'(pk(0, 3, 0)));
        chk("op4_err", 32'(out_err), 0);
        handoff();

        // op5: accept and cfg write in same cycle uses old modulus
        cfg_we = 1'b1;
        run_op(pk(0, 1, 0), pk(0, 3, 0));
        chk("op5_diff_old_mod", 32'(diff_res), 32'(pk(0, 3, 0)));
        handoff();
        cfg_we = 1'b0;

        // op6: new modulus 4 on ch1 now in effect
        run_op(pk(0, 1, 0), pk(0, 3, 0));
        chk("op6_diff_new_mod", 32'(diff_res), 32'(pk(0, 2, 0)));
        handoff();
        chk("op6_count", 32'(op_count), 6);

        // cfg_sel out of range in IDLE is rejected
        cfg_we = 1'b1;
        cfg_sel = 2'd3;
        tick();
        cfg_we = 1'b0;
        chk("sel_range_rej", 32'(cfg_rej), 1);
        tick();
        chk("sel_range_rej_end", 32'(cfg_rej), 0);

        // reset mid-CALC aborts and restores moduli
        a_res = pk(2, 2, 2);
        b_res = pk(1, 1, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_count", 32'(op_count), 0);
        chk("abort_diff", 32'(diff_res), 0);
        run_op(pk(0, 1, 0), pk(0, 3, 0));
        chk("abort_mod_restored", 32'(diff_res), 32'(pk(0, 3, 0)));
        handoff();
        chk("abort_count_after", 32'(op_count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
